// File: rtl/led_pattern_engine.sv
// led_pattern_engine: drives NUM_LEDS outputs with one of four step patterns
// (alternate, all-blink, chase, fill). Every pattern step is held for
// interval_q+1 cycles. Mode and interval are loaded through a valid/ready
// handshake that only opens in IDLE or at a step boundary, so a new
// configuration never cuts a step short.
module led_pattern_engine #(
    parameter int NUM_LEDS = 28,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_interval,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick,
    output logic                running
);

    localparam int FILL_W = $clog2(NUM_LEDS + 1);

    localparam logic [1:0] MODE_ALT   = 2'd0;
    localparam logic [1:0] MODE_ALL   = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_FILL  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      interval_q, interval_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  step_tick_q, step_tick_d;

    logic                  at_boundary_s;
    logic                  accept_s;
    logic [FILL_W-1:0]     fill_next_s;

    // Legacy blinker start pattern: odd bits lit (...1010).
    function automatic logic [NUM_LEDS-1:0] alt_pattern();
        logic [NUM_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            p[i] = ((i % 2) == 1);
        end
        return p;
    endfunction

    // Thermometer code: the lowest 'level' bits lit.
    function automatic logic [NUM_LEDS-1:0] thermo(input logic [FILL_W-1:0] level);
        logic [NUM_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            p[i] = (FILL_W'(i) < level);
        end
        return p;
    endfunction

    assign at_boundary_s = (cnt_q == interval_q);
    assign accept_s      = cfg_valid && cfg_ready;
    assign fill_next_s   = (fill_q == FILL_W'(NUM_LEDS)) ? '0 : (fill_q + FILL_W'(1));

    // Config window: always open when idle, only at an enabled step boundary when running.
    always_comb begin
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: cfg_ready = 1'b1;
            ST_RUN:  cfg_ready = en && at_boundary_s;
            default: cfg_ready = 1'b0;
        endcase
    end

    // Next-state logic: accept overrides the step advance; en=0 freezes everything.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        interval_d  = interval_q;
        cnt_d       = cnt_q;
        led_d       = led_q;
        fill_d      = fill_q;
        step_tick_d = 1'b0;
        if (accept_s) begin
            state_d    = ST_RUN;
            mode_d     = cfg_mode;
            interval_d = cfg_interval;
            cnt_d      = '0;
            fill_d     = '0;
            case (cfg_mode)
                MODE_ALT:   led_d = alt_pattern();
                MODE_ALL:   led_d = {NUM_LEDS{1'b1}};
                MODE_CHASE: led_d = {{(NUM_LEDS-1){1'b0}}, 1'b1};
                MODE_FILL:  led_d = '0;
                default:    led_d = '0;
            endcase
        end else if ((state_q == ST_RUN) && en) begin
            if (at_boundary_s) begin
                cnt_d       = '0;
                step_tick_d = 1'b1;
                case (mode_q)
                    MODE_ALT:   led_d = ~led_q;
                    MODE_ALL:   led_d = ~led_q;
                    MODE_CHASE: led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                    MODE_FILL: begin
                        fill_d = fill_next_s;
                        led_d  = thermo(fill_next_s);
                    end
                    default:    led_d = led_q;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and pattern registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'd0;
            interval_q  <= '0;
            cnt_q       <= '0;
            led_q       <= '0;
            fill_q      <= '0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            interval_q  <= interval_d;
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            fill_q      <= fill_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (NUM_LEDS=8, CNT_W=8).
// A reference model derives the expected LEDs from the step count since the
// last accept; a monitor compares them against the DUT on each falling edge.
module tb_led_pattern_engine;

    localparam int N  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_interval;
    logic [N-1:0]  led;
    logic          step_tick;
    logic          running;

    led_pattern_engine #(.NUM_LEDS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_interval(cfg_interval),
        .led(led), .step_tick(step_tick), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] led;
        logic         tick;
        logic         run;
        logic         bnd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: running flag, config, cycle count in step, step index.
    bit m_run  = 1'b0;
    int m_mode = 0;
    int m_int  = 0;
    int m_cnt  = 0;
    int m_k    = 0;

    function automatic logic [N-1:0] pattern(input int mode, input int k);
        logic [N-1:0] one;
        logic [N:0]   t;
        one = 8'h01;
        case (mode)
            0:       pattern = (k % 2 == 0) ? 8'hAA : 8'h55;
            1:       pattern = (k % 2 == 0) ? 8'hFF : 8'h00;
            2:       pattern = one << (k % N);
            3: begin
                t = (9'd1 << (k % (N + 1))) - 9'd1;
                pattern = t[N-1:0];
            end
            default: pattern = 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   ready;
        bit   tick;
        tick = 1'b0;
        if (!rst) begin
            m_run = 1'b0; m_mode = 0; m_int = 0; m_cnt = 0; m_k = 0;
        end else begin
            ready = !m_run || (en && (m_cnt == m_int));
            if (cfg_valid && ready) begin
                m_run  = 1'b1;
                m_mode = int'(cfg_mode);
                m_int  = int'(cfg_interval);
                m_cnt  = 0;
                m_k    = 0;
            end else if (m_run && en) begin
                if (m_cnt == m_int) begin
                    m_cnt = 0;
                    m_k++;
                    tick = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        e.led  = m_run ? pattern(m_mode, m_k) : 8'h00;
        e.tick = tick;
        e.run  = m_run;
        e.bnd  = (m_cnt == m_int);
        sb_q.push_back(e);
    endtask

    // Model: predict the post-edge outputs from the inputs seen at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        logic exp_ready;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_ready = !e.run || (en && e.bnd);
                check("led", led, e.led);
                check("step_tick", {7'd0, step_tick}, {7'd0, e.tick});
                check("running", {7'd0, running}, {7'd0, e.run});
                check("cfg_ready", {7'd0, cfg_ready}, {7'd0, exp_ready});
            end
        end
    end

    // Hold a config request until the DUT accepts it, with a cycle budget.
    task automatic send_cfg(input logic [1:0] mode, input logic [CW-1:0] interval);
        bit done;
        done = 1'b0;
        #2;
        cfg_valid    = 1'b1;
        cfg_mode     = mode;
        cfg_interval = interval;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                @(posedge clk);
                #2;
                cfg_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL cfg_accept_timeout: got no accept expected accept within 100 cycles");
            cfg_valid = 1'b0;
        end
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        rst = 1'b0; en = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_interval = 8'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(posedge clk);

        send_cfg(2'd0, 8'd3);      // ALT
        repeat (12) @(posedge clk);
        send_cfg(2'd2, 8'd0);      // CHASE every cycle
        repeat (12) @(posedge clk);
        send_cfg(2'd3, 8'd1);      // FILL, 2 cycles per step
        repeat (22) @(posedge clk);

        send_cfg(2'd1, 8'd5);      // ALL, then pause mid-step
        repeat (2) @(posedge clk);
        #2 en = 1'b0;
        repeat (10) @(posedge clk);
        #2 en = 1'b1;
        send_cfg(2'd2, 8'd2);      // reconfigure to CHASE at the boundary
        repeat (8) @(posedge clk);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_led", led, 8'h00);
        check("async_rst_running", {7'd0, running}, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);

        // cfg_valid held high: restart every period.
        #2;
        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_interval = 8'd2;
        repeat (15) @(posedge clk);
        #2 cfg_valid = 1'b0;

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            en           = ($urandom_range(0, 9) != 0);
            cfg_valid    = ($urandom_range(0, 7) == 0);
            cfg_mode     = 2'($urandom_range(0, 3));
            cfg_interval = 8'($urandom_range(0, 4));
        end
        @(posedge clk);
        #2;
        cfg_valid = 1'b0;
        en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
